// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage integer ALU with iterative RISC-V M-extension multiply/divide.
// Accepts one op at a time. The result is registered and held until the consumer takes it.
module alu_mdu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_overflow
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, BUSY, FINISH, DONE} state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [4:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   addend_q;
    logic [2*XLEN-1:0] prod_q;
    logic              neg_q;
    logic              out_valid_q;
    logic [XLEN-1:0]   out_result_q;
    logic              out_zero_q;
    logic              out_overflow_q;

    logic              accept;
    logic              sign_a;
    logic              sign_b;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic              neg_d;
    logic [2*XLEN-1:0] prod_d;
    logic [XLEN-1:0]   addend_d;

    // Accept-time decode: magnitudes, result sign, and divide special cases resolved up front.
    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (in_op[2:0])
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sign_a = 1'b1;
                sign_b = 1'b1;
            end
            3'b010:  sign_a = 1'b1;
            default: ;
        endcase
        a_neg    = sign_a & in_a[XLEN-1];
        b_neg    = sign_b & in_b[XLEN-1];
        mag_a    = a_neg ? -in_a : in_a;
        mag_b    = b_neg ? -in_b : in_b;
        div_zero = in_op[2] && (in_b == '0);
        div_ovf  = in_op[2] && !in_op[0] && (in_a == MIN_VAL) && (in_b == '1);
        special  = in_op[4] && (div_zero || div_ovf);
        // REM/REMU take the dividend's sign; every other op takes sA^sB
        if (special)
            neg_d = 1'b0;
        else if (in_op[2] && in_op[1])
            neg_d = a_neg;
        else
            neg_d = a_neg ^ b_neg;
        if (div_zero)
            prod_d = {in_a, {XLEN{1'b1}}};
        else if (div_ovf)
            prod_d = {{XLEN{1'b0}}, MIN_VAL};
        else if (in_op[2])
            prod_d = {{XLEN{1'b0}}, mag_a};
        else
            prod_d = {{XLEN{1'b0}}, mag_b};
        addend_d = in_op[2] ? mag_b : mag_a;
        accept   = in_valid && (state_q == IDLE) && !kill;
    end

    logic              is_sub;
    logic [XLEN-1:0]   b_eff;
    logic              carry;
    logic [XLEN-1:0]   sum;
    logic              add_ovf;
    logic [XLEN-1:0]   alu_res;

    // Base ALU on the captured operands; subtraction and compares share the A + ~B + 1 adder.
    always_comb begin
        is_sub       = (op_q[3:2] == 2'b10) || ((op_q[3:2] == 2'b00) && op_q[1]);
        b_eff        = is_sub ? ~b_q : b_q;
        {carry, sum} = {1'b0, a_q} + {1'b0, b_eff} + (XLEN+1)'(is_sub);
        add_ovf      = (a_q[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a_q[XLEN-1]);
        alu_res      = a_q;
        case (op_q[3:0])
            4'b0000, 4'b0001, 4'b0010, 4'b0011: alu_res = sum;
            4'b0100: alu_res = a_q & b_q;
            4'b0101: alu_res = a_q | b_q;
            4'b0110: alu_res = a_q ^ b_q;
            4'b0111: alu_res = ~(a_q | b_q);
            4'b1000, 4'b1010: alu_res = {{(XLEN-1){1'b0}}, ~carry};
            4'b1001, 4'b1011: alu_res = {{(XLEN-1){1'b0}}, add_ovf ^ sum[XLEN-1]};
            4'b1100: alu_res = a_q << b_q[SHW-1:0];
            4'b1101: alu_res = a_q >> b_q[SHW-1:0];
            4'b1110: alu_res = $signed(a_q) >>> b_q[SHW-1:0];
            default: alu_res = a_q;
        endcase
    end

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] prod_step;

    // One iteration: shift-add for multiply, restoring step for divide (quotient fills the low half).
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, addend_q} : '0);
        div_shift = prod_q[2*XLEN-1:XLEN-1];
        div_ge    = div_shift >= {1'b0, addend_q};
        div_diff  = div_shift[XLEN-1:0] - addend_q;
        if (op_q[2])
            prod_step = div_ge ? {div_diff, prod_q[XLEN-2:0], 1'b1}
                               : {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
        else
            prod_step = {mul_sum, prod_q[XLEN-1:1]};
    end

    logic [2*XLEN-1:0] mul_full;
    logic [XLEN-1:0]   div_sel;
    logic [XLEN-1:0]   m_res;
    logic [XLEN-1:0]   fin_res;
    logic              fin_ovf;

    always_comb begin
        mul_full = neg_q ? -prod_q : prod_q;
        div_sel  = op_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
        if (op_q[2])
            m_res = neg_q ? -div_sel : div_sel;
        else if (op_q[1:0] == 2'b00)
            m_res = mul_full[XLEN-1:0];
        else
            m_res = mul_full[2*XLEN-1:XLEN];
        fin_res = op_q[4] ? m_res : alu_res;
        fin_ovf = !op_q[4] && (op_q[3:2] == 2'b00) && op_q[0] && add_ovf;
    end

    // Control FSM with registered result; kill in any non-idle state drops the op without a result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            op_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            addend_q       <= '0;
            prod_q         <= '0;
            neg_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_result_q   <= '0;
            out_zero_q     <= 1'b0;
            out_overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q     <= in_op;
                        a_q      <= in_a;
                        b_q      <= in_b;
                        addend_q <= addend_d;
                        prod_q   <= prod_d;
                        neg_q    <= neg_d;
                        cnt_q    <= '0;
                        state_q  <= (!in_op[4] || special) ? FINISH : BUSY;
                    end
                end
                BUSY: begin
                    if (kill) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        prod_q <= prod_step;
                        if (cnt_q == LAST_ITER) begin
                            cnt_q   <= '0;
                            state_q <= FINISH;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    if (kill) begin
                        state_q <= IDLE;
                    end else begin
                        out_result_q   <= fin_res;
                        out_zero_q     <= (fin_res == '0);
                        out_overflow_q <= fin_ovf;
                        out_valid_q    <= 1'b1;
                        state_q        <= DONE;
                    end
                end
                default: begin
                    if (kill || out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_zero     = out_zero_q;
    assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed self-checking bench for alu_mdu at XLEN=32, plus MUL at XLEN=16 and 64.
module tb_alu_mdu;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_overflow;

    logic        v16_in_valid, v16_in_ready, v16_out_valid, v16_out_ready, v16_out_zero, v16_out_ovf;
    logic [4:0]  v16_in_op;
    logic [15:0] v16_in_a, v16_in_b, v16_out_result;
    logic        v64_in_valid, v64_in_ready, v64_out_valid, v64_out_ready, v64_out_zero, v64_out_ovf;
    logic [4:0]  v64_in_op;
    logic [63:0] v64_in_a, v64_in_b, v64_out_result;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ovf;
        int          lat;
    } vec_t;

    always #5 clk = ~clk;

    alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .kill(kill), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_overflow(out_overflow)
    );

    alu_mdu #(.XLEN(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16_in_valid), .in_ready(v16_in_ready),
        .in_op(v16_in_op), .in_a(v16_in_a), .in_b(v16_in_b), .kill(1'b0),
        .out_valid(v16_out_valid), .out_ready(v16_out_ready), .out_result(v16_out_result),
        .out_zero(v16_out_zero), .out_overflow(v16_out_ovf)
    );

    alu_mdu #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64_in_valid), .in_ready(v64_in_ready),
        .in_op(v64_in_op), .in_a(v64_in_a), .in_b(v64_in_b), .kill(1'b0),
        .out_valid(v64_out_valid), .out_ready(v64_out_ready), .out_result(v64_out_result),
        .out_zero(v64_out_zero), .out_overflow(v64_out_ovf)
    );

    // Issues one op, scrambles operands after accept, returns the result and accept-to-valid latency.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic ovf, output logic zero,
                          output int lat);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res  = out_result;
        ovf  = out_overflow;
        zero = out_zero;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_zero !== 1'b0 || out_overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got valid=%b result=%h zero=%b ovf=%b required all 0",
                     out_valid, out_result, out_zero, out_overflow);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic run_table(input string name, input vec_t v [], input int n);
        logic [31:0] res;
        logic        ovf;
        logic        zero;
        int          lat;
        for (int i = 0; i < n; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, res, ovf, zero, lat);
            checks++;
            if (res !== v[i].exp) begin
                failures++;
                $display("[TB] FAIL %s[%0d] result: got %h required %h", name, i, res, v[i].exp);
            end
            checks++;
            if (ovf !== v[i].ovf || zero !== (v[i].exp == 32'h0)) begin
                failures++;
                $display("[TB] FAIL %s[%0d] flags: got ovf=%b zero=%b required ovf=%b zero=%b",
                         name, i, ovf, zero, v[i].ovf, (v[i].exp == 32'h0));
            end
            checks++;
            if (lat != v[i].lat) begin
                failures++;
                $display("[TB] FAIL %s[%0d] latency: got %0d required %0d", name, i, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_alu;
        vec_t v [];
        v = new[17];
        v = '{
            '{5'b00001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 2},
            '{5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 2},
            '{5'b00011, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 2},
            '{5'b00011, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 2},
            '{5'b00010, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 2},
            '{5'b01001, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 2},
            '{5'b01000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 2},
            '{5'b01011, 32'h00000005, 32'hFFFFFFFF, 32'h00000000, 1'b0, 2},
            '{5'b01010, 32'h00000005, 32'hFFFFFFFF, 32'h00000001, 1'b0, 2},
            '{5'b01110, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 2},
            '{5'b01101, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 2},
            '{5'b01100, 32'h00000001, 32'h0000003F, 32'h80000000, 1'b0, 2},
            '{5'b00111, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 1'b0, 2},
            '{5'b00110, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0, 2},
            '{5'b00100, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 2},
            '{5'b00101, 32'hFF00FF00, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 2},
            '{5'b01111, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 1'b0, 2}
        };
        run_table("alu", v, 17);
    endtask

    task automatic test_muldiv;
        vec_t v [];
        v = new[18];
        v = '{
            '{5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34},
            '{5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 34},
            '{5'b10000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 34},
            '{5'b10010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, 34},
            '{5'b10000, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 34},
            '{5'b10001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 34},
            '{5'b10100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 34},
            '{5'b10110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 34},
            '{5'b10100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 34},
            '{5'b10110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34},
            '{5'b10111, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0, 34},
            '{5'b10101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 34},
            '{5'b10111, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 1'b0, 34},
            '{5'b10101, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1'b0, 2},
            '{5'b10100, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 1'b0, 2},
            '{5'b10110, 32'h00001234, 32'h00000000, 32'h00001234, 1'b0, 2},
            '{5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 2},
            '{5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 2}
        };
        run_table("mdu", v, 18);
    endtask

    task automatic test_backpressure;
        int  wait_cnt;
        bit  held_ok;
        in_op    = 5'b10101;
        in_a     = 32'd100;
        in_b     = 32'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = 32'h0;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_ready_after_accept: got %b required 0", in_ready);
        end
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 100) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        held_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_result !== 32'd14 || in_ready !== 1'b0) held_ok = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (!held_ok || out_result !== 32'd14) begin
            failures++;
            $display("[TB] FAIL bp_hold: got valid=%b result=%h ready=%b required valid=1 result=0000000e ready=0",
                     out_valid, out_result, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_release: got ready=%b valid=%b required ready=1 valid=0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_kill;
        bit saw_valid;
        // Kill at the fifth BUSY cycle of a MUL
        in_op    = 5'b10000;
        in_a     = 32'd7;
        in_b     = 32'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL kill_busy_ready: got %b required 1", in_ready);
        end
        saw_valid = 1'b0;
        repeat (40) begin
            if (out_valid) saw_valid = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (saw_valid) begin
            failures++;
            $display("[TB] FAIL kill_busy_no_result: got out_valid pulse=1 required 0");
        end

        // Kill together with a request in IDLE suppresses the accept
        in_op    = 5'b00000;
        in_a     = 32'd1;
        in_b     = 32'd1;
        in_valid = 1'b1;
        kill     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        kill     = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL kill_idle_accept: got in_ready=%b required 1", in_ready);
        end
        saw_valid = 1'b0;
        repeat (4) begin
            if (out_valid) saw_valid = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (saw_valid) begin
            failures++;
            $display("[TB] FAIL kill_idle_no_result: got out_valid pulse=1 required 0");
        end

        // Kill in FINISH
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        kill     = 1'b1;
        @(posedge clk); #1;
        kill     = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL kill_finish: got valid=%b ready=%b required valid=0 ready=1",
                     out_valid, in_ready);
        end

        // Kill with out_ready in DONE
        in_a     = 32'd2;
        in_b     = 32'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd5) begin
            failures++;
            $display("[TB] FAIL kill_done_pre: got valid=%b result=%h required valid=1 result=00000005",
                     out_valid, out_result);
        end
        kill      = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        kill      = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL kill_done: got valid=%b ready=%b required valid=0 ready=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_busy;
        logic [31:0] res;
        logic        ovf;
        logic        zero;
        int          lat;
        run_op(5'b00000, 32'd1, 32'd2, res, ovf, zero, lat);
        in_op    = 5'b10000;
        in_a     = 32'd9;
        in_b     = 32'd9;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_result !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_zero !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_busy: got result=%h valid=%b ready=%b zero=%b required 0/0/1/0 (prior result %h)",
                     out_result, out_valid, in_ready, out_zero, res);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(5'b00000, 32'd4, 32'd5, res, ovf, zero, lat);
        checks++;
        if (res !== 32'd9 || lat != 2) begin
            failures++;
            $display("[TB] FAIL reset_recover: got result=%h lat=%0d required 00000009 lat=2", res, lat);
        end
    endtask

    task automatic test_mul_xlen16;
        int lat;
        v16_in_op    = 5'b10000;
        v16_in_a     = 16'd7;
        v16_in_b     = 16'hFFFD;
        v16_in_valid = 1'b1;
        @(posedge clk); #1;
        v16_in_valid = 1'b0;
        lat = 1;
        while (!v16_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (v16_out_result !== 16'hFFEB || lat != 18) begin
            failures++;
            $display("[TB] FAIL mul_xlen16: got result=%h lat=%0d required ffeb lat=18", v16_out_result, lat);
        end
        v16_out_ready = 1'b1;
        @(posedge clk); #1;
        v16_out_ready = 1'b0;
    endtask

    task automatic test_mul_xlen64;
        int lat;
        v64_in_op    = 5'b10000;
        v64_in_a     = 64'd7;
        v64_in_b     = 64'hFFFFFFFFFFFFFFFD;
        v64_in_valid = 1'b1;
        @(posedge clk); #1;
        v64_in_valid = 1'b0;
        lat = 1;
        while (!v64_out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (v64_out_result !== 64'hFFFFFFFFFFFFFFEB || lat != 66) begin
            failures++;
            $display("[TB] FAIL mul_xlen64: got result=%h lat=%0d required ffffffffffffffeb lat=66",
                     v64_out_result, lat);
        end
        v64_out_ready = 1'b1;
        @(posedge clk); #1;
        v64_out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        kill      = 1'b0;
        out_ready = 1'b0;
        v16_in_valid = 1'b0; v16_in_op = '0; v16_in_a = '0; v16_in_b = '0; v16_out_ready = 1'b0;
        v64_in_valid = 1'b0; v64_in_op = '0; v64_in_a = '0; v64_in_b = '0; v64_out_ready = 1'b0;
        test_reset();
        test_alu();
        test_muldiv();
        test_backpressure();
        test_kill();
        test_reset_mid_busy();
        test_mul_xlen16();
        test_mul_xlen64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion required finish before 1000000ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, multi-cycle successor to the single-cycle integer ALU. Accepts one operation at a time through a valid/ready handshake. Base ALU ops return a registered result after 1 cycle. RISC-V M-extension multiply/divide ops run iteratively over XLEN cycles. Sits in the execute stage and stalls issue through `in_ready`.

## Interface
- `XLEN`, default 32: operand/result width; must be ≥8 and a power of 2.
- `SHW`, default $clog2(XLEN): shift-amount width; B[SHW-1:0] is used.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `in_valid` in 1: request present.
- `in_ready` out 1: block can accept; high only in IDLE.
- `in_op` in 5: [4]=0 selects an ALU op in [3:0]; [4]=1 selects an M op in [2:0].
- `in_a`, `in_b` in XLEN: operands.
- `kill` in 1: abort the in-flight op; no result is produced.
- `out_valid` out 1: result held until it is taken.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out XLEN: result.
- `out_zero` out 1: out_result == 0.
- `out_overflow` out 1: signed overflow, valid for ops 0001/0011 only; 0 for all other ops.

## Operation
- ALU ops (in_op[3:0]):
  - Add/sub: 0000 add, 0001 add with overflow detection, 0010 sub, 0011 sub with overflow detection.
  - Logic: 0100 and, 0101 or, 0110 xor, 0111 nor.
  - Compare: 1000/1010 sltu, 1001/1011 slt.
  - Shift: 1100 sll, 1101 srl, 1110 sra, 1111 pass A.
- Subtraction is A + ~B + 1.
- sltu returns 1 when the carry-out of A − B is 0.
- slt returns (sub overflow XOR sum MSB).
- M ops (in_op[2:0]): 000 MUL (low XLEN), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Multiply:
  - Signed operands are converted to magnitudes at accept.
  - Radix-2 shift-add into a 2·XLEN product register, one bit per cycle.
  - Negate the product in FINISH if the operand signs differ; apply MULHSU sign from A only.
- Divide:
  - Restoring, one quotient bit per cycle, on magnitudes.
  - Quotient sign = sA^sB. Remainder sign = sA.
- Special cases are resolved at accept; the op goes straight to FINISH without BUSY:
  - B=0: quotient = all ones, remainder = A.
  - Signed DIV/REM with A=MIN and B=−1: quotient = MIN, remainder = 0.
- FSM:
  - IDLE→FINISH on accept of an ALU op or a special-case divide.
  - IDLE→BUSY on accept of any other M op.
  - BUSY→FINISH when the iteration counter reaches XLEN−1.
  - FINISH→DONE unconditionally; FINISH latches out_result.
  - DONE→IDLE on out_ready.
- kill: in BUSY or FINISH go to IDLE with out_valid=0. In DONE, kill clears out_valid and goes to IDLE. In IDLE it is ignored (same-cycle accept is suppressed).

## Timing
- Reset (async assert, sync deassert assumed upstream): state=IDLE, counter=0, out_valid=0, out_result=0, out_zero=0, out_overflow=0, in_ready=1 one cycle after reset is released.
- Accept at edge T when in_valid & in_ready.
- Latency from accept edge T to first out_valid cycle:
  - ALU op: out_valid at T+2 (FINISH at T+1, DONE at T+2).
  - Special-case divide: out_valid at T+2.
  - Mul/div: BUSY occupies T+1..T+XLEN, FINISH T+XLEN+1, out_valid at T+XLEN+2.
- out_result, out_zero and out_overflow are stable while out_valid=1 and out_ready=0.
- in_ready=0 from the accept edge until the DONE→IDLE edge; there is no back-to-back overlap.
- Operands are captured at accept; in_a/in_b may change afterwards.
- Reset asserted mid-operation returns to IDLE immediately; no partial result is ever shown.
- kill and out_ready high together in DONE: kill wins, and the result is not counted as delivered.
- Throughput: one op per 3 cycles (ALU) or XLEN+3 cycles (M).

## Test plan
- XLEN=32, op 0001, A=0x7FFFFFFF, B=1 -> out_result=0x80000000, out_overflow=1, out_zero=0, out_valid 2 cycles after accept.
- op 1001 (slt), A=0xFFFFFFFF, B=1 -> 1. op 1000 (sltu), same operands -> 0. op 1110 (sra), A=0x80000000, B=4 -> 0xF8000000.
- op MULH, A=0xFFFFFFFF (−1), B=0xFFFFFFFF -> 0x00000000. MULHU, same operands -> 0xFFFFFFFE. MUL, 7×−3 -> 0xFFFFFFEB. out_valid exactly 34 cycles after accept.
- DIV, A=−7, B=2 -> −3 (0xFFFFFFFD). REM -> −1. DIVU, B=0 -> 0xFFFFFFFF. REM, A=0x80000000, B=−1 -> 0. Special cases return in 2 cycles.
- Backpressure: hold out_ready=0 for 10 cycles after DIVU 100/7 -> result 14 held stable with in_ready=0. out_ready=1 -> IDLE next cycle, in_ready=1.
- Abort: assert kill at BUSY cycle 5 -> no out_valid pulse, in_ready=1 next cycle. Pulse rst_n low mid-BUSY -> all outputs reset immediately. Repeat the MUL scenario with XLEN=16 and XLEN=64.
